// File: rtl/cpu_program_sequencer.sv
// cpu_program_sequencer: loadable 16-bit program store that feeds the cpu's DIN/Run
// one instruction at a time, paced by the cpu's Done. An mvi instruction word is
// followed by its immediate word in the next step.
// Optional build macro SEQ_TIMEOUT_EN: bounds the wait for CpuDone to TIMEOUT_CYCLES,
// ending the run in DONE with Error=1. Without it Error is tied low.
module cpu_program_sequencer #(
  parameter int unsigned ADDR_W         = 5,
  parameter logic [2:0]  MVI_OPCODE     = 3'b001,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              PWr,
  input  logic [ADDR_W-1:0] PAddr,
  input  logic [15:0]       PData,
  input  logic [ADDR_W:0]   ProgLen,
  input  logic              Start,
  input  logic              Abort,
  input  logic              CpuDone,
  output logic [15:0]       DIN,
  output logic              Run,
  output logic              Busy,
  output logic              Finished,
  output logic [ADDR_W-1:0] PC,
  output logic              Error
);

  localparam int unsigned     DEPTH     = 1 << ADDR_W;
  // Word counter carries two extra bits so an mvi in the last slot can step past
  // DEPTH without wrapping before the end-of-program comparison.
  localparam int unsigned     CNT_W     = ADDR_W + 2;
  localparam logic [ADDR_W:0] DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   start_len;
  logic [15:0]       din_q, din_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              fin_q, fin_d;
  logic [15:0]       mem_q [DEPTH];

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              err_q, err_d;
`else
  // TIMEOUT_CYCLES has no effect in this build; referenced only to keep it visible.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  assign start_len = (ProgLen > DEPTH_LEN) ? DEPTH_LEN : ProgLen;

  // Program store: writable only while no program is executing.
  always_ff @(posedge Clock) begin
    if (PWr && (state_q == S_IDLE || state_q == S_DONE)) begin
      mem_q[PAddr] <= PData;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      din_q    <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      fin_q    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      to_cnt_q <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      din_q    <= din_d;
      run_q    <= run_d;
      busy_q   <= busy_d;
      fin_q    <= fin_d;
`ifdef SEQ_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Next-state and word-counter logic; Abort overrides Start and CpuDone.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
`ifdef SEQ_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    err_d    = err_q;
`endif
    if (Abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
`ifdef SEQ_TIMEOUT_EN
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            len_d   = start_len;
            cnt_d   = '0;
            state_d = (start_len == '0) ? S_DONE : S_ISSUE;
`ifdef SEQ_TIMEOUT_EN
            err_d   = 1'b0;
`endif
          end
        end
        S_ISSUE: begin
`ifdef SEQ_TIMEOUT_EN
          to_cnt_d = '0;
`endif
          if (din_q[8:6] == MVI_OPCODE) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_IMM;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_IMM, S_WAIT: begin
          if (CpuDone) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_d >= {1'b0, len_q}) ? S_DONE : S_ISSUE;
          end else begin
            state_d = S_WAIT;
`ifdef SEQ_TIMEOUT_EN
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end else begin
              to_cnt_d = to_cnt_q + TO_W'(1);
            end
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    busy_d = (state_d == S_ISSUE) || (state_d == S_IMM) || (state_d == S_WAIT);
    run_d  = busy_d;
    fin_d  = (state_d == S_DONE);
    din_d  = busy_d ? mem_q[cnt_d[ADDR_W-1:0]] : '0;
  end

  assign DIN      = din_q;
  assign Run      = run_q;
  assign Busy     = busy_q;
  assign Finished = fin_q;
  assign PC       = cnt_q[ADDR_W-1:0];
`ifdef SEQ_TIMEOUT_EN
  assign Error    = err_q;
`else
  assign Error    = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_program_sequencer.sv
// Testbench for cpu_program_sequencer: vector table, hand-written corner sequences and
// randomized programs checked against a transaction-level model of the expected trace.
module tb_cpu_program_sequencer;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 32;

  logic              Clock = 1'b0;
  logic              Reset, PWr, Start, Abort, CpuDone;
  logic [ADDR_W-1:0] PAddr;
  logic [15:0]       PData;
  logic [ADDR_W:0]   ProgLen;
  logic [15:0]       DIN;
  logic              Run, Busy, Finished, Error;
  logic [ADDR_W-1:0] PC;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] shadow [DEPTH];

  always #5 Clock = ~Clock;

  cpu_program_sequencer #(.ADDR_W(ADDR_W), .MVI_OPCODE(3'b001), .TIMEOUT_CYCLES(16)) dut (
    .Clock(Clock), .Reset(Reset), .PWr(PWr), .PAddr(PAddr), .PData(PData),
    .ProgLen(ProgLen), .Start(Start), .Abort(Abort), .CpuDone(CpuDone),
    .DIN(DIN), .Run(Run), .Busy(Busy), .Finished(Finished), .PC(PC), .Error(Error)
  );

  typedef struct {
    bit              start;
    bit              abort;
    bit              done;
    logic [ADDR_W:0] plen;
    bit              e_run;
    bit              e_busy;
    bit              e_fin;
    bit              chk_pc;
    logic [4:0]      e_pc;
    logic [15:0]     e_din;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic chk_out(input string tag, input bit run, input bit busy, input bit fin,
                         input bit chk_pc, input logic [4:0] pc, input logic [15:0] din,
                         input bit err);
    chk({tag, ".Run"}, 32'(Run), 32'(run));
    chk({tag, ".Busy"}, 32'(Busy), 32'(busy));
    chk({tag, ".Finished"}, 32'(Finished), 32'(fin));
    chk({tag, ".DIN"}, 32'(DIN), 32'(din));
    chk({tag, ".Error"}, 32'(Error), 32'(err));
    if (chk_pc) chk({tag, ".PC"}, 32'(PC), 32'(pc));
  endtask

  task automatic store_write(input logic [4:0] a, input logic [15:0] d);
    PWr = 1'b1; PAddr = a; PData = d;
    tick();
    PWr = 1'b0;
    shadow[a] = d;
  endtask

  // Expected trace built from the program: each word gets one issue cycle; an mvi
  // consumes the following word as its immediate; the wait phase lasts until Done.
  task automatic run_prog(input int unsigned plen, input bit rnd, output int unsigned busy_cycles);
    int unsigned len, pc, nwait;
    logic [15:0] word;
    string tag;
    len = (plen > DEPTH) ? DEPTH : plen;
    pc = 0;
    busy_cycles = 0;
    ProgLen = (ADDR_W+1)'(plen);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    if (len == 0) begin
      chk_out("len0", 0, 0, 1, 1, 5'd0, 16'h0, 0);
      return;
    end
    while (pc < len) begin
      tag = $sformatf("prog.issue%0d", pc);
      word = shadow[pc % DEPTH];
      chk_out(tag, 1, 1, 0, 1, 5'(pc % DEPTH), word, 0);
      busy_cycles++;
      CpuDone = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rnd) begin
        PWr = 1'($urandom_range(0, 1)); PAddr = 5'($urandom); PData = 16'($urandom);
      end
      if (word[8:6] == 3'b001) pc++;
      if (rnd) nwait = $urandom_range(0, 3);
      else nwait = (word[8:6] == 3'b010 || word[8:6] == 3'b011) ? 2 : 0;
      tick();
      for (int unsigned k = 0; k <= nwait; k++) begin
        tag = $sformatf("prog.wait%0d_%0d", pc, k);
        chk_out(tag, 1, 1, 0, 1, 5'(pc % DEPTH), shadow[pc % DEPTH], 0);
        busy_cycles++;
        CpuDone = (k == nwait);
        tick();
      end
      CpuDone = 1'b0;
      pc++;
    end
    PWr = 1'b0;
    chk_out("prog.end", 0, 0, 1, 0, 5'd0, 16'h0, 0);
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned cyc, plen, nw;
    logic [15:0] w;

    Reset = 1'b1; PWr = 1'b0; Start = 1'b0; Abort = 1'b0; CpuDone = 1'b0;
    PAddr = '0; PData = '0; ProgLen = '0;
    tick(); tick();
    chk_out("reset", 0, 0, 0, 1, 5'd0, 16'h0, 0);
    Reset = 1'b0;

    for (int i = 3; i < DEPTH; i++) store_write(5'(i), 16'($urandom));
    store_write(5'd0, 16'h0040);
    store_write(5'd1, 16'h000A);
    store_write(5'd2, 16'h0008);

    tbl[0]  = '{0, 0, 0, 6'd0,  0, 0, 0, 1, 5'd0, 16'h0000};
    tbl[1]  = '{1, 0, 0, 6'd2,  1, 1, 0, 1, 5'd0, 16'h0040};
    tbl[2]  = '{0, 0, 0, 6'd0,  1, 1, 0, 1, 5'd1, 16'h000A};
    tbl[3]  = '{0, 0, 0, 6'd0,  1, 1, 0, 1, 5'd1, 16'h000A};
    tbl[4]  = '{0, 0, 1, 6'd0,  0, 0, 1, 0, 5'd0, 16'h0000};
    tbl[5]  = '{0, 0, 0, 6'd0,  0, 0, 1, 0, 5'd0, 16'h0000};
    tbl[6]  = '{1, 0, 0, 6'd0,  0, 0, 1, 1, 5'd0, 16'h0000};
    tbl[7]  = '{0, 1, 0, 6'd0,  0, 0, 0, 1, 5'd0, 16'h0000};
    tbl[8]  = '{1, 0, 0, 6'd0,  0, 0, 1, 1, 5'd0, 16'h0000};
    tbl[9]  = '{1, 1, 0, 6'd2,  0, 0, 0, 1, 5'd0, 16'h0000};
    tbl[10] = '{1, 0, 0, 6'd1,  1, 1, 0, 1, 5'd0, 16'h0040};
    tbl[11] = '{0, 0, 1, 6'd0,  1, 1, 0, 1, 5'd1, 16'h000A};
    tbl[12] = '{0, 0, 1, 6'd0,  0, 0, 1, 0, 5'd0, 16'h0000};
    tbl[13] = '{1, 0, 0, 6'd2,  1, 1, 0, 1, 5'd0, 16'h0040};
    tbl[14] = '{0, 0, 0, 6'd0,  1, 1, 0, 1, 5'd1, 16'h000A};
    tbl[15] = '{1, 1, 1, 6'd0,  0, 0, 0, 1, 5'd0, 16'h0000};
    tbl[16] = '{1, 0, 0, 6'd63, 1, 1, 0, 1, 5'd0, 16'h0040};
    tbl[17] = '{0, 1, 0, 6'd0,  0, 0, 0, 1, 5'd0, 16'h0000};

    for (int i = 0; i < NV; i++) begin
      Start = tbl[i].start; Abort = tbl[i].abort; CpuDone = tbl[i].done; ProgLen = tbl[i].plen;
      tick();
      Start = 1'b0; Abort = 1'b0; CpuDone = 1'b0;
      chk_out($sformatf("vec%0d", i), tbl[i].e_run, tbl[i].e_busy, tbl[i].e_fin,
              tbl[i].chk_pc, tbl[i].e_pc, tbl[i].e_din, 0);
    end

    // mvi R0,#A ; mvi R1,#8 ; add R0,R1
    store_write(5'd0, 16'h0040);
    store_write(5'd1, 16'h000A);
    store_write(5'd2, 16'h0048);
    store_write(5'd3, 16'h0008);
    store_write(5'd4, 16'h0081);

    // Reset while waiting; the same-edge write must not reach the store.
    ProgLen = 6'd5; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk_out("rst_mid.issue", 1, 1, 0, 1, 5'd0, 16'h0040, 0);
    tick();
    tick();
    chk_out("rst_mid.wait", 1, 1, 0, 1, 5'd1, 16'h000A, 0);
    PWr = 1'b1; PAddr = 5'd1; PData = 16'hDEAD; Reset = 1'b1;
    tick();
    PWr = 1'b0; Reset = 1'b0;
    chk_out("rst_mid.after", 0, 0, 0, 1, 5'd0, 16'h0000, 0);

    run_prog(5, 1'b0, cyc);
    chk("prog3.busy_cycles", 32'(cyc), 32'd8);

    // Write attempted in WAIT, then Abort with CpuDone and Start on the same edge.
    ProgLen = 6'd5; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    PWr = 1'b1; PAddr = 5'd2; PData = 16'hBEEF;
    tick();
    PWr = 1'b0;
    chk_out("pwr_wait", 1, 1, 0, 1, 5'd1, 16'h000A, 0);
    Abort = 1'b1; CpuDone = 1'b1; Start = 1'b1;
    tick();
    Abort = 1'b0; CpuDone = 1'b0; Start = 1'b0;
    chk_out("abort_wait", 0, 0, 0, 1, 5'd0, 16'h0000, 0);
    tick();
    chk_out("abort_idle", 0, 0, 0, 1, 5'd0, 16'h0000, 0);

    run_prog(5, 1'b0, cyc);
    chk("prog3b.busy_cycles", 32'(cyc), 32'd8);

    // CpuDone never arrives.
    store_write(5'd0, 16'h0000);
    ProgLen = 6'd1; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk_out("stuck.issue", 1, 1, 0, 1, 5'd0, 16'h0000, 0);
`ifdef SEQ_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_out($sformatf("stuck.wait%0d", i), 1, 1, 0, 1, 5'd0, 16'h0000, 0);
    end
    tick();
    chk_out("stuck.timeout", 0, 0, 1, 0, 5'd0, 16'h0000, 1);
    tick();
    chk_out("stuck.hold", 0, 0, 1, 0, 5'd0, 16'h0000, 1);
    ProgLen = 6'd0; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk_out("stuck.clear", 0, 0, 1, 1, 5'd0, 16'h0000, 0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      chk($sformatf("stuck.busy%0d", i), 32'(Busy), 32'd1);
    end
    chk("stuck.error", 32'(Error), 32'd0);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk_out("stuck.abort", 0, 0, 0, 1, 5'd0, 16'h0000, 0);
`endif

    // Random programs, lengths beyond DEPTH included, ignored writes while busy.
    for (int it = 0; it < 40; it++) begin
      nw = $urandom_range(1, 8);
      for (int j = 0; j < int'(nw); j++) begin
        w = 16'($urandom);
        w[8:6] = 3'($urandom_range(0, 3));
        store_write(5'($urandom), w);
      end
      plen = $urandom_range(0, 40);
      run_prog(plen, 1'b1, cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
